rgb_to_grey_pipe: RTL and testbench
===================================

// Module: rgb_to_grey_pipe
// PURPOSE
//  Parametrised, pipelined RGB->grey converter with valid/ready flow control.
//  Sits between the pixel source (camera/frame reader) and the convolution line buffers.
//  Adds selectable modes, runtime coefficients, round-half-up with saturation,
//  backpressure and an end-of-line sideband.
// PARAMETERS
//  CH_W    4  bits per colour channel; pixel_in is 3*CH_W bits, {R,G,B}, R in MSBs
//  OUT_W   4  grey output width; legal range 1 <= OUT_W <= CH_W+FRAC
//  COEF_W  5  unsigned coefficient width
//  FRAC    4  coefficient fraction bits (weights sum to 2^FRAC for unity gain)
//  KR/KG/KB  5/9/2  fixed weights used in MODE_WEIGHTED
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  pixel_in   in   3*CH_W   {R,G,B}
//  in_valid   in   1        pixel_in/in_last/mode/cfg_k* valid this cycle
//  in_ready   out  1        block accepts a beat this cycle
//  in_last    in   1        end-of-line marker, travels with the pixel
//  mode       in   2        00 weighted, 01 max(R,G,B), 10 green only, 11 runtime coeffs
//  cfg_kr     in   COEF_W   runtime R weight (mode 11)
//  cfg_kg     in   COEF_W   runtime G weight (mode 11)
//  cfg_kb     in   COEF_W   runtime B weight (mode 11)
//  pixel_out  out  OUT_W    grey result
//  out_valid  out  1        pixel_out/out_last valid
//  out_ready  in   1        downstream accepts
//  out_last   out  1        delayed in_last
// BEHAVIOUR
//  - Transfer on valid&ready at either side. mode and cfg_k* are sampled per beat, with the pixel.
//  - Two register stages:
//    S1 = products R*k, G*k, B*k (each CH_W+COEF_W bits) plus mode/last;
//    S2 = sum, round, saturate -> pixel_out/out_last.
//  - Latency 2 cycles in -> out when unstalled; throughput 1 pixel/cycle.
//  - Flow control:
//    s2_en = !out_valid | out_ready;
//    s1_en = !s1_valid | s2_en;
//    in_ready = s1_en (combinational, no dependency on in_valid).
//  - Bubbles collapse: an empty S1 loads even while S2 is stalled.
//  - Stall: while out_valid & !out_ready, pixel_out/out_last are held stable.
//    A stalled pipeline holds 2 beats, then in_ready=0.
//  - S1 captures when s1_en: s1_valid <= in_valid. S2 captures when s2_en: out_valid <= s1_valid.
//  - Weighted/runtime: sum = Rk+Gk+Bk, width CH_W+COEF_W+2, no overflow.
//    SH = FRAC+CH_W-OUT_W.
//    If SH>0: y = (sum + 2^(SH-1)) >> SH, else y = sum << -SH.
//    Saturate to 2^OUT_W-1 if y overflows.
//  - Max/green: the channel value is MSB-aligned into OUT_W bits
//    (zero-pad LSBs, or drop LSBs, no rounding).
//  - Reset: out_valid=0, s1_valid=0, pixel_out=0, out_last=0, in_ready=1 in the first cycle after reset.
//    A reset mid-stream discards all in-flight beats.
//  - Reset dominates: a beat presented during rst is not captured.
//  - in_last is never generated or dropped by the block; it is only delayed with its pixel.
// TESTING
//  1. mode 00, pixel 0xFFF -> 15; 0x800 -> 3 (40+8=48>>4); 0x000 -> 0; each at out 2 cycles after accept.
//  2. mode 01, 0x3A5 -> 10; mode 10, 0x3A5 -> 10; mode 11, k=16/0/0, 0x700 -> 7;
//     k=31/31/31, 0xFFF -> saturate 15.
//  3. Stream of 8 pixels, out_ready=1 -> 8 outputs on consecutive cycles, in order, with out_last on the 8th only.
//  4. Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 beats are held;
//     pixel_out is stable; no loss or duplication on release.
//  5. Alternate mode 00/11 every beat with changing cfg_k* -> each output matches its own beat's mode/coeffs.
//  6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle;
//     no stale output appears; the next beat has normal 2-cycle latency.

Source files
------------

// File: rtl/rgb_to_grey_pipe_if.sv
// Pixel stream bundle for rgb_to_grey_pipe: RGB input beat with sideband and
// per-beat configuration, grey output beat with end-of-line marker.
interface rgb_to_grey_pipe_if #(
   parameter int CH_W   = 4,
   parameter int OUT_W  = 4,
   parameter int COEF_W = 5
);
   logic [3*CH_W-1:0] pixel_in;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [1:0]        mode;
   logic [COEF_W-1:0] cfg_kr;
   logic [COEF_W-1:0] cfg_kg;
   logic [COEF_W-1:0] cfg_kb;
   logic [OUT_W-1:0]  pixel_out;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   // Source/sink side (frame reader feeding, line buffer consuming).
   modport master (
      output pixel_in, in_valid, in_last, mode, cfg_kr, cfg_kg, cfg_kb, out_ready,
      input  in_ready, pixel_out, out_valid, out_last
   );

   // Converter side.
   modport slave (
      input  pixel_in, in_valid, in_last, mode, cfg_kr, cfg_kg, cfg_kb, out_ready,
      output in_ready, pixel_out, out_valid, out_last
   );
endinterface

// File: rtl/rgb_to_grey_pipe.sv
// Two-stage RGB->grey converter: S1 registers per-channel products, S2 sums,
// rounds half-up and saturates (or MSB-aligns a single channel for max/green).
module rgb_to_grey_pipe #(
   parameter int CH_W   = 4,
   parameter int OUT_W  = 4,
   parameter int COEF_W = 5,
   parameter int FRAC   = 4,
   parameter int KR     = 5,
   parameter int KG     = 9,
   parameter int KB     = 2
) (
   input  logic                clk,
   input  logic                rst,
   rgb_to_grey_pipe_if.slave   bus
);

   localparam int PW     = CH_W + COEF_W;
   localparam int SUM_W  = PW + 2;
   localparam int SH     = FRAC + CH_W - OUT_W;
   localparam int LSH    = (SH < 0) ? -SH : 0;
   localparam int WIDE_W = SUM_W + 1 + LSH;

   localparam logic [COEF_W-1:0] KR_C = COEF_W'(KR);
   localparam logic [COEF_W-1:0] KG_C = COEF_W'(KG);
   localparam logic [COEF_W-1:0] KB_C = COEF_W'(KB);
   localparam logic [WIDE_W-1:0] OUT_MAX = (WIDE_W'(1) << OUT_W) - WIDE_W'(1);

   localparam logic [1:0] MODE_WEIGHTED = 2'b00;
   localparam logic [1:0] MODE_MAX      = 2'b01;
   localparam logic [1:0] MODE_GREEN    = 2'b10;
   localparam logic [1:0] MODE_RUNTIME  = 2'b11;

   // Handshake: a beat moves across a boundary on the cycle where valid and
   // ready are both high; in_ready depends only on pipeline state, never on
   // in_valid, and a presented output beat stays unchanged until accepted.
   logic s2_en;
   logic s1_en;

   logic [CH_W-1:0]   r_in, g_in, b_in;
   logic [COEF_W-1:0] kr_sel, kg_sel, kb_sel;
   logic [CH_W-1:0]   chan_sel;

   logic              s1_valid_q, s1_valid_d;
   logic [PW-1:0]     s1_pr_q, s1_pr_d;
   logic [PW-1:0]     s1_pg_q, s1_pg_d;
   logic [PW-1:0]     s1_pb_q, s1_pb_d;
   logic [CH_W-1:0]   s1_chan_q, s1_chan_d;
   logic [1:0]        s1_mode_q, s1_mode_d;
   logic              s1_last_q, s1_last_d;

   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  pixel_out_q, pixel_out_d;
   logic              out_last_q, out_last_d;

   logic [SUM_W-1:0]  sum;
   logic [WIDE_W-1:0] wide_sum;
   logic [WIDE_W-1:0] y_full;
   logic [OUT_W-1:0]  weighted_grey;
   logic [OUT_W-1:0]  aligned;
   logic [OUT_W-1:0]  s2_result;

   assign s2_en = !out_valid_q || bus.out_ready;
   assign s1_en = !s1_valid_q || s2_en;

   assign bus.in_ready  = s1_en;
   assign bus.out_valid = out_valid_q;
   assign bus.pixel_out = pixel_out_q;
   assign bus.out_last  = out_last_q;

   // Input decode: channel split, weight select and single-channel pick.
   always_comb begin
      r_in = bus.pixel_in[3*CH_W-1 -: CH_W];
      g_in = bus.pixel_in[2*CH_W-1 -: CH_W];
      b_in = bus.pixel_in[CH_W-1:0];

      kr_sel = (bus.mode == MODE_RUNTIME) ? bus.cfg_kr : KR_C;
      kg_sel = (bus.mode == MODE_RUNTIME) ? bus.cfg_kg : KG_C;
      kb_sel = (bus.mode == MODE_RUNTIME) ? bus.cfg_kb : KB_C;

      chan_sel = g_in;
      if (bus.mode == MODE_MAX) begin
         chan_sel = r_in;
         if (g_in > chan_sel) chan_sel = g_in;
         if (b_in > chan_sel) chan_sel = b_in;
      end
   end

   // Sum of three products cannot overflow SUM_W; one extra bit absorbs the
   // rounding constant before the shift.
   always_comb begin
      sum      = SUM_W'(s1_pr_q) + SUM_W'(s1_pg_q) + SUM_W'(s1_pb_q);
      wide_sum = WIDE_W'(sum);
   end

   generate
      if (SH > 0) begin : g_round
         always_comb y_full = (wide_sum + (WIDE_W'(1) << (SH - 1))) >> SH;
      end else begin : g_shl
         always_comb y_full = wide_sum << LSH;
      end

      if (OUT_W >= CH_W) begin : g_pad
         always_comb aligned = OUT_W'(s1_chan_q) << (OUT_W - CH_W);
      end else begin : g_drop
         always_comb aligned = s1_chan_q[CH_W-1 -: OUT_W];
      end
   endgenerate

   always_comb begin
      if (y_full > OUT_MAX) begin
         weighted_grey = '1;
      end else begin
         weighted_grey = y_full[OUT_W-1:0];
      end

      case (s1_mode_q)
         MODE_MAX, MODE_GREEN: s2_result = aligned;
         default:              s2_result = weighted_grey;
      endcase
   end

   // Next-state: each stage loads only when its enable is high; data
   // registers only move with a real beat so idle stages keep old contents.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_pr_d     = s1_pr_q;
      s1_pg_d     = s1_pg_q;
      s1_pb_d     = s1_pb_q;
      s1_chan_d   = s1_chan_q;
      s1_mode_d   = s1_mode_q;
      s1_last_d   = s1_last_q;
      out_valid_d = out_valid_q;
      pixel_out_d = pixel_out_q;
      out_last_d  = out_last_q;

      if (s1_en) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_pr_d   = PW'(r_in) * PW'(kr_sel);
            s1_pg_d   = PW'(g_in) * PW'(kg_sel);
            s1_pb_d   = PW'(b_in) * PW'(kb_sel);
            s1_chan_d = chan_sel;
            s1_mode_d = bus.mode;
            s1_last_d = bus.in_last;
         end
      end

      if (s2_en) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            pixel_out_d = s2_result;
            out_last_d  = s1_last_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_pr_q     <= '0;
         s1_pg_q     <= '0;
         s1_pb_q     <= '0;
         s1_chan_q   <= '0;
         s1_mode_q   <= MODE_WEIGHTED;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         pixel_out_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pr_q     <= s1_pr_d;
         s1_pg_q     <= s1_pg_d;
         s1_pb_q     <= s1_pb_d;
         s1_chan_q   <= s1_chan_d;
         s1_mode_q   <= s1_mode_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         pixel_out_q <= pixel_out_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_rgb_to_grey_pipe.sv
// Bench for rgb_to_grey_pipe: directed spec points plus randomized traffic
// checked by an arithmetic reference model and an in-order scoreboard.
module tb_rgb_to_grey_pipe;

   localparam int CH_W   = 4;
   localparam int OUT_W  = 4;
   localparam int COEF_W = 5;
   localparam int FRAC   = 4;
   localparam int KR     = 5;
   localparam int KG     = 9;
   localparam int KB     = 2;
   localparam int PIX_W  = 3 * CH_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rgb_to_grey_pipe_if #(.CH_W(CH_W), .OUT_W(OUT_W), .COEF_W(COEF_W)) bus ();

   rgb_to_grey_pipe #(
      .CH_W(CH_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .FRAC(FRAC),
      .KR(KR), .KG(KG), .KB(KB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_mis = 0;
   logic [OUT_W:0] exp_q[$];   // {last, grey}
   bit rand_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [OUT_W-1:0] ref_grey(input logic [PIX_W-1:0] pix, input logic [1:0] m,
                                                 input int kr, input int kg, input int kb);
      int r, g, b, s, sh, y, c, maxv;
      r = int'(pix[PIX_W-1 -: CH_W]);
      g = int'(pix[2*CH_W-1 -: CH_W]);
      b = int'(pix[CH_W-1:0]);
      maxv = (1 << OUT_W) - 1;
      sh = FRAC + CH_W - OUT_W;
      if (m == 2'b00 || m == 2'b11) begin
         if (m == 2'b00) begin
            kr = KR; kg = KG; kb = KB;
         end
         s = r * kr + g * kg + b * kb;
         if (sh > 0) y = (s + (1 << (sh - 1))) / (1 << sh);
         else        y = s * (1 << (-sh));
         if (y > maxv) y = maxv;
      end else begin
         if (m == 2'b01) begin
            c = r;
            if (g > c) c = g;
            if (b > c) c = b;
         end else begin
            c = g;
         end
         if (OUT_W >= CH_W) y = c * (1 << (OUT_W - CH_W));
         else               y = c / (1 << (CH_W - OUT_W));
      end
      return OUT_W'(y);
   endfunction

   // ---------------- scoreboard / monitor ----------------
   initial begin
      logic stall_prev;
      logic [OUT_W-1:0] held_pix;
      logic held_last;
      logic [OUT_W:0] e;
      stall_prev = 1'b0;
      held_pix = '0;
      held_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check_eq("hold_valid", bus.out_valid, 1);
               check_eq("hold_pix", bus.pixel_out, held_pix);
               check_eq("hold_last", bus.out_last, held_last);
            end
            if (bus.in_valid && bus.in_ready)
               exp_q.push_back({bus.in_last, ref_grey(bus.pixel_in, bus.mode, int'(bus.cfg_kr),
                                                      int'(bus.cfg_kg), int'(bus.cfg_kb))});
            if (bus.out_valid && bus.out_ready) begin
               check_eq("sb_pending", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_eq("sb_pix", bus.pixel_out, e[OUT_W-1:0]);
                  check_eq("sb_last", bus.out_last, e[OUT_W]);
               end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_pix = bus.pixel_out;
            held_last = bus.out_last;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called in the #1-after-posedge phase; returns in the same phase after acceptance.
   task automatic send_beat(input logic [PIX_W-1:0] pix, input logic [1:0] m,
                            input logic [COEF_W-1:0] kr, input logic [COEF_W-1:0] kg,
                            input logic [COEF_W-1:0] kb, input logic last);
      int waited = 0;
      bus.pixel_in = pix;
      bus.mode     = m;
      bus.cfg_kr   = kr;
      bus.cfg_kg   = kg;
      bus.cfg_kb   = kb;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) check_eq("in_ready_wait", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_rand(input logic [1:0] m, input logic last);
      send_beat(PIX_W'($urandom_range(0, (1 << PIX_W) - 1)), m,
                COEF_W'($urandom_range(0, (1 << COEF_W) - 1)),
                COEF_W'($urandom_range(0, (1 << COEF_W) - 1)),
                COEF_W'($urandom_range(0, (1 << COEF_W) - 1)), last);
   endtask

   // Single beat into an idle pipe: checks acceptance, 2-cycle latency and value.
   task automatic directed(input logic [PIX_W-1:0] pix, input logic [1:0] m,
                           input logic [COEF_W-1:0] kr, input logic [COEF_W-1:0] kg,
                           input logic [COEF_W-1:0] kb, input int exp_v, input string tag);
      int lat;
      bus.out_ready = 1'b1;
      bus.pixel_in  = pix;
      bus.mode      = m;
      bus.cfg_kr    = kr;
      bus.cfg_kg    = kg;
      bus.cfg_kb    = kb;
      bus.in_last   = 1'b0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check_eq({tag, "_acc"}, bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_lat"}, lat, 2);
      check_eq(tag, bus.pixel_out, exp_v);
      tick(2);
   endtask

   task automatic drain(input string tag);
      int w = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq(tag, exp_q.size(), 0);
      tick(2);
   endtask

   task automatic wait_out_valid(input string tag);
      int w = 0;
      @(negedge clk);
      while (!bus.out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.out_valid) check_eq(tag, bus.out_valid, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [OUT_W-1:0] held;
      rst = 1'b1;
      bus.pixel_in  = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.mode      = 2'b00;
      bus.cfg_kr    = '0;
      bus.cfg_kg    = '0;
      bus.cfg_kb    = '0;
      bus.out_ready = 1'b1;
      rand_done     = 1'b0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_pixel_out", bus.pixel_out, 0);
      check_eq("rst_out_last", bus.out_last, 0);
      check_eq("rst_in_ready", bus.in_ready, 1);
      tick(1);

      // Fixed spec points
      directed(12'hFFF, 2'b00, 5'd0, 5'd0, 5'd0, 15, "w_fff");
      directed(12'h800, 2'b00, 5'd0, 5'd0, 5'd0, 3, "w_800");
      directed(12'h000, 2'b00, 5'd0, 5'd0, 5'd0, 0, "w_000");
      directed(12'h3A5, 2'b01, 5'd0, 5'd0, 5'd0, 10, "max_3a5");
      directed(12'h3A5, 2'b10, 5'd0, 5'd0, 5'd0, 10, "grn_3a5");
      directed(12'h700, 2'b11, 5'd16, 5'd0, 5'd0, 7, "rt_700");
      directed(12'hFFF, 2'b11, 5'd31, 5'd31, 5'd31, 15, "rt_sat");

      // Stream of 8 back-to-back, last on the 8th only
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand(2'($urandom_range(0, 3)), (i == 7));
         end
         begin
            wait_out_valid("s3_first");
            for (int i = 0; i < 8; i++) begin
               check_eq("s3_consec", bus.out_valid, 1);
               check_eq("s3_last", bus.out_last, (i == 7));
               @(negedge clk);
            end
         end
      join
      drain("s3_drain");

      // Mid-stream stall of 5 cycles
      fork
         begin
            for (int i = 0; i < 10; i++) send_rand(2'($urandom_range(0, 3)), (i == 9));
         end
         begin
            held = '0;
            wait_out_valid("s4_first");
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check_eq("s4_in_ready", bus.in_ready, 0);
               check_eq("s4_valid", bus.out_valid, 1);
               if (i == 0) held = bus.pixel_out;
               else check_eq("s4_stable", bus.pixel_out, held);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain("s4_drain");

      // Alternating weighted / runtime coefficients every beat
      for (int i = 0; i < 20; i++) send_rand((i % 2 == 0) ? 2'b00 : 2'b11, (i == 19));
      drain("s5_drain");

      // Reset with two beats in flight, plus a beat offered during reset
      bus.out_ready = 1'b0;
      send_rand(2'b00, 1'b0);
      send_rand(2'b11, 1'b1);
      rst = 1'b1;
      bus.pixel_in = 12'hFFF;
      bus.mode     = 2'b00;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("s6_out_valid", bus.out_valid, 0);
      check_eq("s6_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("s6_no_stale", bus.out_valid, 0);
      end
      tick(1);
      directed(12'h800, 2'b00, 5'd0, 5'd0, 5'd0, 3, "s6_after");

      // Randomized traffic with random gaps and random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send_rand(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
               if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      n_mis++;
      $display("FAIL watchdog: run not finished at t=%0t, expected completion", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $fatal(1, "watchdog expired");
   end

endmodule
